// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

    localparam int unsigned PC_W    = 32;
    localparam int unsigned INSTR_W = 32;

    // Primary opcodes of the absolute jumps that the fetch stage may predecode
    localparam logic [5:0] OPC_J   = 6'b000010;
    localparam logic [5:0] OPC_JAL = 6'b000011;

    // beq $0,$0,-1: a branch to itself marks the end of the program
    localparam logic [INSTR_W-1:0] HALT_INSTR_DEF = 32'h1000_FFFF;

    // Force word alignment and wrap into a memory of 'words' words (power of two)
    function automatic logic [PC_W-1:0] wrap_pc(input logic [PC_W-1:0] pc,
                                                 input int unsigned     words);
        logic [PC_W-1:0] mask;
        mask = PC_W'(words * 4 - 1);
        return pc & mask & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/ifu_next_pc.sv
// Next fetch address: sequential pc+4 with wrap, or an absolute j/jal target
// when the fetch-stage jump predecode is enabled (macro IFU_JUMP_PREDECODE_EN).
module ifu_next_pc
    import ifu_pkg::*;
#(
    parameter int unsigned IMEM_WORDS = 256
) (
    input  logic [PC_W-1:0]    i_pc,
    input  logic [INSTR_W-1:0] i_instr,
    output logic [PC_W-1:0]    o_next_pc
);

    logic [PC_W-1:0] w_pc_plus4;

    assign w_pc_plus4 = i_pc + 32'd4;

`ifdef IFU_JUMP_PREDECODE_EN
    logic w_is_jump;

    assign w_is_jump = (i_instr[31:26] == OPC_J) || (i_instr[31:26] == OPC_JAL);

    // Jump target uses the region of the delay-slot address, as decode would
    always_comb begin
        o_next_pc = wrap_pc(w_pc_plus4, IMEM_WORDS);
        if (w_is_jump) begin
            o_next_pc = wrap_pc({w_pc_plus4[31:28], i_instr[25:0], 2'b00}, IMEM_WORDS);
        end
    end
`else
    // Without predecode the instruction word does not influence the next PC
    logic w_unused_instr;

    assign w_unused_instr = ^i_instr;

    // Purely sequential fetch
    always_comb begin
        o_next_pc = wrap_pc(w_pc_plus4, IMEM_WORDS);
    end
`endif

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, reads a combinational instruction
// memory and hands words to decode through a registered valid/ready stage.
// Handles downstream redirects, halt on the self-loop word and, when the
// macro IFU_JUMP_PREDECODE_EN is defined, fetch-stage j/jal predecode.
module instr_fetch_unit
    import ifu_pkg::*;
#(
    parameter logic [PC_W-1:0]    RESET_PC   = 32'h0000_0000,
    parameter int unsigned        IMEM_WORDS = 256,     // must be a power of two
    parameter logic [INSTR_W-1:0] HALT_INSTR = HALT_INSTR_DEF
) (
    input  logic               clk,
    input  logic               reset,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_instr,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_pc,
    output logic [PC_W-1:0]    out_pc_plus4,
    output logic               halted,
    output logic [31:0]        instr_count
);

    localparam logic [PC_W-1:0] RESET_PC_ALIGNED = RESET_PC & 32'hFFFF_FFFC;

    logic [PC_W-1:0]    r_pc;
    logic               r_out_valid;
    logic [INSTR_W-1:0] r_out_instr;
    logic [PC_W-1:0]    r_out_pc;
    logic [PC_W-1:0]    r_out_pc_plus4;
    logic               r_halted;
    logic [31:0]        r_instr_count;

    logic               w_can_load;
    logic               w_accept;
    logic               w_is_halt;
    logic [PC_W-1:0]    w_next_pc;
    logic [PC_W-1:0]    w_redirect_target;

    // Output slot is free when empty or being drained this cycle
    assign w_can_load        = !r_out_valid || out_ready;
    assign w_accept          = r_out_valid && out_ready;
    assign w_is_halt         = (imem_instr == HALT_INSTR);
    assign w_redirect_target = wrap_pc(redirect_pc, IMEM_WORDS);

    ifu_next_pc #(
        .IMEM_WORDS (IMEM_WORDS)
    ) u_next_pc (
        .i_pc      (r_pc),
        .i_instr   (imem_instr),
        .o_next_pc (w_next_pc)
    );

    // PC, output stage and halt flag: redirect > halted > load > stall
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc           <= RESET_PC_ALIGNED;
            r_out_valid    <= 1'b0;
            r_out_instr    <= '0;
            r_out_pc       <= '0;
            r_out_pc_plus4 <= '0;
            r_halted       <= 1'b0;
        end else if (redirect_valid) begin
            // Flush whatever is waiting; an acceptance this cycle is still counted
            r_pc        <= w_redirect_target;
            r_out_valid <= 1'b0;
            r_halted    <= 1'b0;
        end else if (r_halted) begin
            if (w_accept) begin
                r_out_valid <= 1'b0;
            end
        end else if (w_can_load) begin
            r_out_instr    <= imem_instr;
            r_out_pc       <= r_pc;
            r_out_pc_plus4 <= r_pc + 32'd4;
            r_out_valid    <= 1'b1;
            if (w_is_halt) begin
                // Keep pointing at the halt word so imem_addr shows where we stopped
                r_halted <= 1'b1;
            end else begin
                r_pc <= w_next_pc;
            end
        end
    end

    // Saturating count of instructions handed to decode
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_instr_count <= '0;
        end else if (w_accept && (r_instr_count != 32'hFFFF_FFFF)) begin
            r_instr_count <= r_instr_count + 32'd1;
        end
    end

    assign imem_addr    = r_pc;
    assign out_valid    = r_out_valid;
    assign out_instr    = r_out_instr;
    assign out_pc       = r_out_pc;
    assign out_pc_plus4 = r_out_pc_plus4;
    assign halted       = r_halted;
    assign instr_count  = r_instr_count;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: a program-order reference model
// predicts each word handed to decode; a negedge monitor compares.
module tb_instr_fetch_unit;

    localparam logic [31:0] NOP  = 32'h0000_1820;
    localparam logic [31:0] HALT = 32'h1000_FFFF;
    localparam int unsigned MEM_BYTES = 1024;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
    } item_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus4;
    logic        halted;
    logic [31:0] instr_count;

    logic [31:0] mem [256];

    // Reference model state
    item_t       exp_q [$];
    logic [31:0] m_pc;
    logic        m_halted;
    int unsigned m_acc;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    assign imem_instr = mem[imem_addr[9:2]];

    instr_fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_pc_plus4   (out_pc_plus4),
        .halted         (halted),
        .instr_count    (instr_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Address of the next instruction in program order after word w at pc
    function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] w);
        logic [31:0] t;
        t = (pc + 32'd4) % MEM_BYTES;
`ifdef IFU_JUMP_PREDECODE_EN
        if (w[31:26] == 6'd2 || w[31:26] == 6'd3) begin
            t = (((pc + 32'd4) & 32'hF000_0000) | {4'b0, w[25:0], 2'b00}) % MEM_BYTES;
        end
`else
        if (w == 32'hFFFF_FFFF) t = t;
`endif
        return t;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_pc     = 32'h0;
        m_halted = 1'b0;
        m_acc    = 0;
    endtask

    // Advance the model over the edge just taken, using the inputs that were
    // applied during the cycle before it (accepted items already popped)
    task automatic model_step();
        item_t it;
        if (reset) return;
        if (redirect_valid) begin
            exp_q.delete();
            m_pc     = {redirect_pc[31:2], 2'b00} % MEM_BYTES;
            m_halted = 1'b0;
        end else if (!m_halted && exp_q.size() == 0) begin
            it.instr = mem[m_pc[9:2]];
            it.pc    = m_pc;
            it.pc4   = m_pc + 32'd4;
            exp_q.push_back(it);
            if (it.instr == HALT) m_halted = 1'b1;
            else                  m_pc = model_next(m_pc, it.instr);
        end
    endtask

    task automatic tick(input logic rdy, input logic rv, input logic [31:0] rp);
        @(posedge clk);
        #1;
        model_step();
        out_ready      = rdy;
        redirect_valid = rv;
        redirect_pc    = rp;
    endtask

    // Asynchronous reset asserted mid-cycle, released just after an edge
    task automatic do_reset();
        #1;
        reset          = 1'b1;
        redirect_valid = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset     = 1'b0;
        out_ready = 1'b1;
    endtask

    // Monitor: compare DUT state against the model away from the active edge
    initial begin
        item_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                chk("rst_valid", {31'b0, out_valid}, 32'h0);
                chk("rst_instr", out_instr, 32'h0);
                chk("rst_pc", out_pc, 32'h0);
                chk("rst_pc4", out_pc_plus4, 32'h0);
                chk("rst_halted", {31'b0, halted}, 32'h0);
                chk("rst_count", instr_count, 32'h0);
                chk("rst_addr", imem_addr, 32'h0);
            end else begin
                chk("out_valid", {31'b0, out_valid}, {31'b0, exp_q.size() != 0});
                chk("imem_addr", imem_addr, m_pc);
                chk("halted", {31'b0, halted}, {31'b0, m_halted});
                chk("instr_count", instr_count, m_acc);
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_output at %0t: got pc %h expected none",
                                 $time, out_pc);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_instr", out_instr, e.instr);
                        chk("out_pc", out_pc, e.pc);
                        chk("out_pc_plus4", out_pc_plus4, e.pc4);
                    end
                    m_acc++;
                end
            end
        end
    end

    // Overall time bound
    initial begin
        #2_000_000;
        $display("FAIL timeout: got no end of test expected end of test");
        $fatal(1, "timeout");
    end

    initial begin
        reset          = 1'b1;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        for (int i = 0; i < 256; i++) mem[i] = NOP;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        reset     = 1'b0;
        out_ready = 1'b1;

        // Streaming at full rate
        repeat (20) tick(1'b1, 1'b0, 32'h0);

        // Three-cycle stall, then random backpressure
        repeat (3) tick(1'b0, 1'b0, 32'h0);
        repeat (5) tick(1'b1, 1'b0, 32'h0);
        repeat (40) tick(1'($urandom_range(0, 3) != 0), 1'b0, 32'h0);

        // Redirect to an unaligned target while a word is waiting
        tick(1'b1, 1'b0, 32'h0);
        tick(1'b1, 1'b1, 32'h0000_0012);
        tick(1'b1, 1'b0, 32'h0);
        chk("redir_addr", imem_addr, 32'h10);
        chk("redir_flush", {31'b0, out_valid}, 32'h0);
        repeat (10) tick(1'b1, 1'b0, 32'h0);

        // Halt word at 0x34, then restart from 0
        mem[13] = HALT;
        do_reset();
        repeat (30) tick(1'b1, 1'b0, 32'h0);
        chk("halt_flag", {31'b0, halted}, 32'h1);
        chk("halt_addr", imem_addr, 32'h34);
        chk("halt_drained", {31'b0, out_valid}, 32'h0);
        tick(1'b1, 1'b1, 32'h0);
        tick(1'b1, 1'b0, 32'h0);
        chk("unhalt_flag", {31'b0, halted}, 32'h0);
        chk("unhalt_addr", imem_addr, 32'h0);
        mem[13] = NOP;
        repeat (10) tick(1'b1, 1'b0, 32'h0);

        // Run through the top of memory to exercise the wrap
        do_reset();
        repeat (300) tick(1'b1, 1'b0, 32'h0);

        // Jump word at 0x20
        mem[8] = 32'h0800_0005;
        do_reset();
        repeat (20) tick(1'b1, 1'b0, 32'h0);
        mem[8] = NOP;

        // Random program, backpressure and redirects, one halt planted
        for (int i = 0; i < 256; i++) begin
            mem[i] = $urandom;
            if (mem[i] == HALT) mem[i] = NOP;
        end
        mem[$urandom_range(0, 255)] = HALT;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            if (c == 300) do_reset();
            tick(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0), $urandom);
        end
        tick(1'b1, 1'b0, 32'h0);
        @(negedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Initiator side of the instruction-memory read interface. It owns the PC and drives the word-aligned fetch address. It samples the combinational instruction word returned in the same cycle and presents it to decode through a registered valid/ready stage. It handles stalls, redirects (beq/jr resolved downstream), an optional fetch-stage jump predecode, and halt detection on the self-loop "beq $0,$0,-1".

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] forced to 0.
- IMEM_WORDS, 256, instruction memory depth in words; PC wraps modulo IMEM_WORDS*4; power of two required.
- HALT_INSTR, 32'h1000_FFFF, encoding treated as program end (beq $0,$0,-1).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- imem_addr  out  32  fetch address = current PC (combinational from PC register).
- imem_instr  in  32  instruction word from memory, valid in the same cycle as imem_addr.
- redirect_valid  in  1  downstream control transfer (taken branch, jr).
- redirect_pc  in  32  target PC for the redirect.
- out_valid  out  1  out_instr/out_pc hold a fetched instruction.
- out_ready  in  1  decode accepts the instruction this cycle.
- out_instr  out  32  fetched instruction.
- out_pc  out  32  PC of out_instr.
- out_pc_plus4  out  32  out_pc+4, unwrapped, for the jal/branch base.
- halted  out  1  HALT_INSTR fetched; fetching stopped.
- instr_count  out  32  instructions accepted (out_valid && out_ready), saturating at 32'hFFFF_FFFF.

Behaviour:
- Reset (async, active-high) values:
  - pc = RESET_PC & ~3
  - out_valid = 0, out_instr = 0, out_pc = 0, out_pc_plus4 = 0
  - halted = 0, instr_count = 0
- Define can_load = !out_valid || out_ready.
- Priority per rising edge:
  1. redirect_valid:
     - pc <= {redirect_pc[31:2],2'b00} mod IMEM_WORDS*4
     - out_valid <= 0 (flush; a handshake on out_valid && out_ready this cycle still counts)
     - halted <= 0
     - no capture this cycle
  2. halted: no capture, pc held; out_valid drains normally (cleared on acceptance).
  3. can_load:
     - out_instr <= imem_instr, out_pc <= pc, out_pc_plus4 <= pc+4, out_valid <= 1
     - pc <= next_pc
     - if imem_instr == HALT_INSTR: halted <= 1 and pc is held (not advanced)
  4. otherwise (stall): all state held; imem_addr stable.
- In state 3, if out_valid && out_ready, the old word is consumed and the new word is loaded in the same edge. Sustained throughput is 1 instruction/cycle.
- next_pc = (pc+4) mod IMEM_WORDS*4, so 0x3FC wraps to 0x000 at the defaults.
- Latency: instruction at PC p appears on out_* one edge after pc==p with can_load.
- Halt word is presented once on out_* like any instruction; instr_count counts it.
- Reset asserted mid-stall or mid-halt returns immediately to the reset values. Fetch resumes from RESET_PC on the first edge after deassert.
- No handshake on the memory side; the memory is assumed combinational, never stalls.

Optional Feature:
- Macro IFU_JUMP_PREDECODE_EN.
- Defined: when capturing, if imem_instr[31:26] is 6'b000010 (j) or 6'b000011 (jal), next_pc = {pc_plus4[31:28], imem_instr[25:0], 2'b00} mod IMEM_WORDS*4. This removes the redirect bubble. The instruction is still forwarded so decode can write $31 for jal, and decode must not redirect on it.
- Undefined: j/jal are treated as sequential; decode redirects, costing one flushed slot.

Decomposition:
- Package ifu_pkg: OPC_J=6'b000010, OPC_JAL=6'b000011, HALT_INSTR default, PC_W=32, INSTR_W=32.
- Optional small combinational sub-module ifu_next_pc (inputs pc, instr; output next_pc) holds the wrap and predecode logic. Everything else lives in one module.

Test Plan:
- Reset, memory returns 0x0000_1820 at each address, out_ready=1 -> out_pc 0,4,8,... on consecutive cycles; out_valid=1 from the first edge after reset; instr_count increments each cycle.
- Hold out_ready=0 for 3 cycles with out_valid=1 -> out_instr/out_pc/imem_addr frozen; instr_count unchanged; resumes with the next PC and no skipped or duplicated instruction.
- redirect_valid with redirect_pc=0x0000_0012 while out_valid=1 -> out_valid=0 next cycle; imem_addr=0x10; the next out_pc=0x10.
- Memory word at 0x34 = 0x1000_FFFF -> that word is presented once, then halted=1, out_valid drops after acceptance, imem_addr stays 0x34; a redirect to 0 clears halted and fetches from 0.
- PC reaches 0x3FC -> next out_pc = 0x000 (wrap); out_pc_plus4 for the 0x3FC fetch = 0x400.
- With IFU_JUMP_PREDECODE_EN, word 0x0800_0005 at 0x20 -> next out_pc = 0x14 with no flushed slot; without the macro, next out_pc = 0x24.
